// File: rtl/onehot_to_bin_stream.sv
// One-hot to binary encoder with a single valid/ready output register stage.
// Define ONEHOT_TO_BIN_STREAM_ERRCNT_EN to build the saturating multi-hot error counter.
module onehot_to_bin_stream #(
  parameter int ONEHOT_WIDTH = 16,
  parameter int NUM_CH       = 1,
  parameter int PRIO         = 0,
  parameter int CNT_WIDTH    = 16,
  localparam int BIN_WIDTH   = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [NUM_CH*ONEHOT_WIDTH-1:0] onehot_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [NUM_CH*BIN_WIDTH-1:0]    bin_o,
  output logic [NUM_CH-1:0]              zero_o,
  output logic [NUM_CH-1:0]              multi_o,
  output logic [CNT_WIDTH-1:0]           err_cnt_o
);

  logic                        valid_q, valid_d;
  logic [NUM_CH*BIN_WIDTH-1:0] bin_q, bin_d, binEnc;
  logic [NUM_CH-1:0]           zero_q, zero_d, zeroEnc;
  logic [NUM_CH-1:0]           multi_q, multi_d, multiEnc;
  logic                        accept;

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    logic [ONEHOT_WIDTH-1:0] chVec;
    logic [BIN_WIDTH-1:0]    enc;
    logic                    seen;
    logic                    many;

    assign chVec = onehot_i[c*ONEHOT_WIDTH +: ONEHOT_WIDTH];

    // PRIO=0 ORs every set index together; PRIO=1 keeps only the first (lowest) one.
    always_comb begin
      enc  = '0;
      seen = 1'b0;
      many = 1'b0;
      for (int i = 0; i < ONEHOT_WIDTH; i++) begin
        if (chVec[i]) begin
          if (PRIO == 0) begin
            enc = enc | BIN_WIDTH'(i);
          end else if (!seen) begin
            enc = BIN_WIDTH'(i);
          end
          if (seen) begin
            many = 1'b1;
          end
          seen = 1'b1;
        end
      end
    end

    assign binEnc[c*BIN_WIDTH +: BIN_WIDTH] = enc;
    assign zeroEnc[c]  = !seen;
    assign multiEnc[c] = many;
  end

  always_comb begin
    valid_d = valid_q;
    bin_d   = bin_q;
    zero_d  = zero_q;
    multi_d = multi_q;
    if (accept) begin
      valid_d = 1'b1;
      bin_d   = binEnc;
      zero_d  = zeroEnc;
      multi_d = multiEnc;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      bin_q   <= '0;
      zero_q  <= '0;
      multi_q <= '0;
    end else begin
      valid_q <= valid_d;
      bin_q   <= bin_d;
      zero_q  <= zero_d;
      multi_q <= multi_d;
    end
  end

  assign valid_o = valid_q;
  assign bin_o   = bin_q;
  assign zero_o  = zero_q;
  assign multi_o = multi_q;

`ifdef ONEHOT_TO_BIN_STREAM_ERRCNT_EN
  logic [CNT_WIDTH-1:0] errCnt_q, errCnt_d;

  // Clear beats a simultaneous increment; the count sticks at all-ones.
  always_comb begin
    errCnt_d = errCnt_q;
    if (clr_i) begin
      errCnt_d = '0;
    end else if (accept && (|multiEnc) && (errCnt_q != '1)) begin
      errCnt_d = errCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      errCnt_q <= '0;
    end else begin
      errCnt_q <= errCnt_d;
    end
  end

  assign err_cnt_o = errCnt_q;
`else
  logic unusedClr;
  assign unusedClr = clr_i;
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_onehot_to_bin_stream.sv
// Directed bench for onehot_to_bin_stream: two instances (PRIO=0 with a 2-bit counter, PRIO=1 with a 16-bit counter).
module tb_onehot_to_bin_stream;

  localparam int OW = 8;
  localparam int NC = 2;
  localparam int BW = 3;
`ifdef ONEHOT_TO_BIN_STREAM_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             validIn;
  logic             readyIn;
  logic [NC*OW-1:0] onehot;

  logic             ready0, valid0, ready1, valid1;
  logic [NC*BW-1:0] bin0, bin1;
  logic [NC-1:0]    zero0, multi0, zero1, multi1;
  logic [1:0]       err0;
  logic [15:0]      err1;

  int checks = 0;
  int errors = 0;
  int cnt0   = 0;
  int cnt1   = 0;

  always #5 clk = ~clk;

  onehot_to_bin_stream #(.ONEHOT_WIDTH(OW), .NUM_CH(NC), .PRIO(0), .CNT_WIDTH(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .valid_i(validIn), .ready_o(ready0),
    .onehot_i(onehot), .valid_o(valid0), .ready_i(readyIn), .bin_o(bin0),
    .zero_o(zero0), .multi_o(multi0), .err_cnt_o(err0)
  );

  onehot_to_bin_stream #(.ONEHOT_WIDTH(OW), .NUM_CH(NC), .PRIO(1), .CNT_WIDTH(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .valid_i(validIn), .ready_o(ready1),
    .onehot_i(onehot), .valid_o(valid1), .ready_i(readyIn), .bin_o(bin1),
    .zero_o(zero1), .multi_o(multi1), .err_cnt_o(err1)
  );

  typedef struct packed {
    logic [7:0] ch0;
    logic [7:0] ch1;
    logic [2:0] p0b0;
    logic [2:0] p0b1;
    logic [2:0] p1b0;
    logic [2:0] p1b1;
    logic [1:0] zero;
    logic [1:0] multi;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] c0, input logic [7:0] c1,
                               input logic rdy, input logic cl);
    validIn = v;
    onehot  = {c1, c0};
    readyIn = rdy;
    clr     = cl;
  endtask

  function automatic void countBeat(input logic [1:0] m);
    if (|m) begin
      if (cnt0 < 3) cnt0++;
      if (cnt1 < 65535) cnt1++;
    end
  endfunction

  task automatic checkOutput(input string name, input logic expValid,
                             input logic [5:0] expBinP0, input logic [5:0] expBinP1,
                             input logic [1:0] expZero, input logic [1:0] expMulti,
                             input logic checkData);
    check({name, ".valid0"}, 32'(valid0), 32'(expValid));
    check({name, ".valid1"}, 32'(valid1), 32'(expValid));
    if (checkData) begin
      check({name, ".bin0"},   32'(bin0),   32'(expBinP0));
      check({name, ".bin1"},   32'(bin1),   32'(expBinP1));
      check({name, ".zero0"},  32'(zero0),  32'(expZero));
      check({name, ".zero1"},  32'(zero1),  32'(expZero));
      check({name, ".multi0"}, 32'(multi0), 32'(expMulti));
      check({name, ".multi1"}, 32'(multi1), 32'(expMulti));
    end
    check({name, ".err0"}, 32'(err0), ERR_EN ? 32'(cnt0) : 32'd0);
    check({name, ".err1"}, 32'(err1), ERR_EN ? 32'(cnt1) : 32'd0);
  endtask

  task automatic checkReady(input string name, input logic exp);
    check({name, ".ready0"}, 32'(ready0), 32'(exp));
    check({name, ".ready1"}, 32'(ready1), 32'(exp));
  endtask

  initial begin
    //                ch0    ch1    p0b0  p0b1  p1b0  p1b1  zero   multi
    vecs[0] = '{8'h10, 8'h01, 3'd4, 3'd0, 3'd4, 3'd0, 2'b00, 2'b00};
    vecs[1] = '{8'h12, 8'h00, 3'd5, 3'd0, 3'd1, 3'd0, 2'b10, 2'b01};
    vecs[2] = '{8'h00, 8'h00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b11, 2'b00};
    vecs[3] = '{8'h80, 8'hFF, 3'd7, 3'd7, 3'd7, 3'd0, 2'b00, 2'b10};
    vecs[4] = '{8'h06, 8'h40, 3'd3, 3'd6, 3'd1, 3'd6, 2'b00, 2'b01};
    vecs[5] = '{8'h00, 8'hA0, 3'd0, 3'd7, 3'd0, 3'd5, 2'b01, 2'b10};
    vecs[6] = '{8'h02, 8'h08, 3'd1, 3'd3, 3'd1, 3'd3, 2'b00, 2'b00};
    vecs[7] = '{8'h18, 8'h24, 3'd7, 3'd7, 3'd3, 3'd2, 2'b00, 2'b11};

    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("reset", 1'b0, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1);
    checkReady("reset", 1'b1);
    rst = 1'b0;

    // Back-to-back table beats at full throughput
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, vecs[k].ch0, vecs[k].ch1, 1'b1, 1'b0);
      tick();
      countBeat(vecs[k].multi);
      checkOutput($sformatf("vec%0d", k), 1'b1,
                  {vecs[k].p0b1, vecs[k].p0b0}, {vecs[k].p1b1, vecs[k].p1b0},
                  vecs[k].zero, vecs[k].multi, 1'b1);
    end

    // Invalid input is ignored and the stage drains
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    tick();
    checkOutput("bubble", 1'b0, 6'd0, 6'd0, 2'b00, 2'b00, 1'b0);

    // Clear coinciding with a multi-hot beat wins
    applyStimulus(1'b1, 8'h12, 8'h00, 1'b1, 1'b1);
    tick();
    cnt0 = 0;
    cnt1 = 0;
    checkOutput("clrWins", 1'b1, {3'd0, 3'd5}, {3'd0, 3'd1}, 2'b10, 2'b01, 1'b1);

    applyStimulus(1'b1, 8'h12, 8'h00, 1'b1, 1'b0);
    tick();
    countBeat(2'b01);
    checkOutput("multiInc", 1'b1, {3'd0, 3'd5}, {3'd0, 3'd1}, 2'b10, 2'b01, 1'b1);

    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("allZero", 1'b1, 6'd0, 6'd0, 2'b11, 2'b00, 1'b1);

    // Backpressure: X held for three stalled cycles, then Y follows exactly once
    applyStimulus(1'b1, 8'h10, 8'h01, 1'b1, 1'b0);
    tick();
    checkOutput("bpX", 1'b1, {3'd0, 3'd4}, {3'd0, 3'd4}, 2'b00, 2'b00, 1'b1);
    applyStimulus(1'b1, 8'h02, 8'h08, 1'b0, 1'b0);
    #1;
    checkReady("bpStallComb", 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      checkOutput($sformatf("bpStall%0d", s), 1'b1, {3'd0, 3'd4}, {3'd0, 3'd4}, 2'b00, 2'b00, 1'b1);
      checkReady($sformatf("bpStall%0d", s), 1'b0);
    end
    readyIn = 1'b1;
    #1;
    checkReady("bpRelease", 1'b1);
    tick();
    checkOutput("bpY", 1'b1, {3'd3, 3'd1}, {3'd3, 3'd1}, 2'b00, 2'b00, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("bpDrain", 1'b0, 6'd0, 6'd0, 2'b00, 2'b00, 1'b0);

    // Reset while a beat is stalled in the output stage
    applyStimulus(1'b1, 8'h18, 8'h24, 1'b1, 1'b0);
    tick();
    countBeat(2'b11);
    checkOutput("preRst", 1'b1, {3'd7, 3'd7}, {3'd2, 3'd3}, 2'b00, 2'b11, 1'b1);
    applyStimulus(1'b1, 8'h06, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("preRstHold", 1'b1, {3'd7, 3'd7}, {3'd2, 3'd3}, 2'b00, 2'b11, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h06, 8'h00, 1'b1, 1'b0);
    tick();
    cnt0 = 0;
    cnt1 = 0;
    checkOutput("rstMid", 1'b0, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checkReady("rstMid", 1'b1);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
